// File: rtl/ufs_rx_sync_ctrl.sv
// ufs_rx_sync_ctrl
// ----------------------------------------------------------------------------
// Receive-lane symbol controller sitting between the word aligner and the
// combinational 8b/10b decoder. Each accepted 10-bit symbol is classified
// (code error, disparity error, comma, control), running disparity is tracked,
// and a comma-based LOSS -> ACQ -> SYNC state machine decides whether the lane
// is synchronised. Symbols are forwarded through one register stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sym_in     received symbol, abcdei = [9:4], fghj = [3:0]
//   sym_valid  sym_in valid this cycle
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   sym_out    registered symbol to decoder data_in
//   k_out      registered control-symbol flag to decoder k_in
//   out_valid  registered sym_valid qualified by "state was SYNC"
//   sym_err    registered code/disparity error flag of the last symbol
//   sync_ok    lane is in SYNC
//   rd_pos     current running disparity (1 = RD+)
//   err_cnt    saturating count of bad symbols seen while in SYNC
//   dbg_state  raw FSM state (0 LOSS, 1 ACQ, 2 SYNC) for checkers
//
// Handshake: there is no back-pressure. A symbol is accepted on every rising
// edge where sym_valid=1; cycles with sym_valid=0 hold all state and produce
// out_valid=0 on the following cycle.
// ----------------------------------------------------------------------------
module ufs_rx_sync_ctrl #(
  parameter int ACQ_COMMAS   = 3,
  parameter int BAD_LIMIT    = 4,
  parameter int GOOD_RECOVER = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       sym_in,
  input  logic             sym_valid,
  input  logic             err_clr,
  output logic [9:0]       sym_out,
  output logic             k_out,
  output logic             out_valid,
  output logic             sym_err,
  output logic             sync_ok,
  output logic             rd_pos,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_LOSS = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;

  // Counter widths leave one spare count so "count + 1" never wraps before
  // it is compared with its limit.
  localparam int ACQ_W  = $clog2(ACQ_COMMAS + 2);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 2);
  localparam int GOOD_W = $clog2(GOOD_RECOVER + 2);

  localparam logic [ACQ_W-1:0]  ACQ_LIM  = ACQ_W'(ACQ_COMMAS);
  localparam logic [BAD_W-1:0]  BAD_LIM  = BAD_W'(BAD_LIMIT);
  localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(GOOD_RECOVER);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [ACQ_W-1:0] acq_cnt_q,   acq_cnt_d;
  logic [BAD_W-1:0] bad_cnt_q,   bad_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic             rd_q,        rd_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic [9:0]       sym_q,       sym_d;
  logic             k_q,         k_d;
  logic             out_valid_q, out_valid_d;
  logic             sym_err_q,   sym_err_d;

  // --------------------------------------------------------------------------
  // Symbol classification
  // --------------------------------------------------------------------------
  logic [3:0] n1;
  logic       code_err;
  logic       disp_err;
  logic       bad_sym;
  logic       comma_pos;
  logic       comma_neg;
  logic       is_comma;
  logic       is_k;
  logic       rd_norm;

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n1 = n1 + {3'b000, sym_in[i]};
    end
  end

  always_comb begin
    code_err  = !((n1 == 4'd4) || (n1 == 4'd5) || (n1 == 4'd6));
    // Disparity is only meaningful for a legal-weight symbol.
    disp_err  = !code_err && (((n1 == 4'd6) && rd_q) || ((n1 == 4'd4) && !rd_q));
    bad_sym   = code_err || disp_err;
    comma_pos = (sym_in[9:3] == 7'b0011111);
    comma_neg = (sym_in[9:3] == 7'b1100000);
    is_comma  = (comma_pos || comma_neg) && !bad_sym;
  end

  // K28.x is recognised by its 6b prefix; the four Kx.7 codes by full match.
  always_comb begin
    is_k = (sym_in[9:4] == 6'b001111) || (sym_in[9:4] == 6'b110000);
    case (sym_in)
      10'b1110101000, 10'b0001010111,
      10'b1101101000, 10'b0010010111,
      10'b1011101000, 10'b0100010111,
      10'b0111101000, 10'b1000010111: is_k = 1'b1;
      default: ;
    endcase
  end

  // Running disparity after a symbol while RD is being tracked normally.
  // A code-error symbol has no defined disparity, so RD is left alone.
  always_comb begin
    rd_norm = rd_q;
    if (!code_err) begin
      if (n1 == 4'd6) begin
        rd_norm = 1'b1;
      end else if (n1 == 4'd4) begin
        rd_norm = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic err_inc;

  always_comb begin
    state_d     = state_q;
    acq_cnt_d   = acq_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    good_cnt_d  = good_cnt_q;
    rd_d        = rd_q;
    sym_d       = sym_q;
    k_d         = k_q;
    sym_err_d   = sym_err_q;
    out_valid_d = sym_valid && (state_q == ST_SYNC);
    err_inc     = 1'b0;

    if (sym_valid) begin
      sym_d     = sym_in;
      k_d       = is_k;
      sym_err_d = bad_sym;

      case (state_q)
        ST_LOSS: begin
          // RD is held at RD- while lost; the first comma re-seeds it from
          // its polarity.
          if (is_comma) begin
            rd_d = comma_pos;
            if (ACQ_COMMAS <= 1) begin
              state_d   = ST_SYNC;
              acq_cnt_d = '0;
            end else begin
              state_d   = ST_ACQ;
              acq_cnt_d = ACQ_W'(1);
            end
          end
        end

        ST_ACQ: begin
          rd_d = rd_norm;
          if (bad_sym) begin
            state_d    = ST_LOSS;
            acq_cnt_d  = '0;
            bad_cnt_d  = '0;
            good_cnt_d = '0;
            rd_d       = 1'b0;
          end else if (is_comma) begin
            if ((acq_cnt_q + ACQ_W'(1)) >= ACQ_LIM) begin
              state_d   = ST_SYNC;
              acq_cnt_d = '0;
            end else begin
              acq_cnt_d = acq_cnt_q + ACQ_W'(1);
            end
          end
        end

        ST_SYNC: begin
          rd_d = rd_norm;
          if (bad_sym) begin
            err_inc = 1'b1;
            if ((bad_cnt_q + BAD_W'(1)) >= BAD_LIM) begin
              state_d    = ST_LOSS;
              acq_cnt_d  = '0;
              bad_cnt_d  = '0;
              good_cnt_d = '0;
              rd_d       = 1'b0;
            end else begin
              bad_cnt_d  = bad_cnt_q + BAD_W'(1);
              good_cnt_d = '0;
            end
          end else begin
            if ((good_cnt_q + GOOD_W'(1)) >= GOOD_LIM) begin
              if (bad_cnt_q != '0) begin
                bad_cnt_d  = bad_cnt_q - BAD_W'(1);
                good_cnt_d = '0;
              end else begin
                // Nothing to retire: park the run length at the limit.
                good_cnt_d = GOOD_LIM;
              end
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end
        end

        default: begin
          state_d    = ST_LOSS;
          acq_cnt_d  = '0;
          bad_cnt_d  = '0;
          good_cnt_d = '0;
          rd_d       = 1'b0;
        end
      endcase
    end
  end

  // Error counter: clear has priority over a coincident increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_inc && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOSS;
      acq_cnt_q   <= '0;
      bad_cnt_q   <= '0;
      good_cnt_q  <= '0;
      rd_q        <= 1'b0;
      err_cnt_q   <= '0;
      sym_q       <= '0;
      k_q         <= 1'b0;
      out_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acq_cnt_q   <= acq_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rd_q        <= rd_d;
      err_cnt_q   <= err_cnt_d;
      sym_q       <= sym_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      sym_err_q   <= sym_err_d;
    end
  end

  assign sym_out   = sym_q;
  assign k_out     = k_q;
  assign out_valid = out_valid_q;
  assign sym_err   = sym_err_q;
  assign sync_ok   = (state_q == ST_SYNC);
  assign rd_pos    = rd_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ufs_rx_sync_ctrl.sv
// Testbench for ufs_rx_sync_ctrl (built with a 4-bit error counter so that
// saturation is reachable quickly).
module tb_ufs_rx_sync_ctrl;

  localparam int ACQ  = 3;
  localparam int BADL = 4;
  localparam int GREC = 4;
  localparam int CW   = 4;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    sym_in;
  logic          sym_valid;
  logic          err_clr;
  logic [9:0]    sym_out;
  logic          k_out;
  logic          out_valid;
  logic          sym_err;
  logic          sync_ok;
  logic          rd_pos;
  logic [CW-1:0] err_cnt;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  ufs_rx_sync_ctrl #(
    .ACQ_COMMAS  (ACQ),
    .BAD_LIMIT   (BADL),
    .GOOD_RECOVER(GREC),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_in   (sym_in),
    .sym_valid(sym_valid),
    .err_clr  (err_clr),
    .sym_out  (sym_out),
    .k_out    (k_out),
    .out_valid(out_valid),
    .sym_err  (sym_err),
    .sync_ok  (sync_ok),
    .rd_pos   (rd_pos),
    .err_cnt  (err_cnt),
    .dbg_state(dbg_state)
  );

  // --------------------------------------------------------------------------
  // Counters and check helper
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference model (rules of the lane, not its registers)
  // --------------------------------------------------------------------------
  localparam logic [9:0] K_LIST [8] = '{10'b1110101000, 10'b0001010111,
                                        10'b1101101000, 10'b0010010111,
                                        10'b1011101000, 10'b0100010111,
                                        10'b0111101000, 10'b1000010111};

  bit        m_locked;   // lane synchronised
  int        m_commas;   // commas collected since losing lock (0 = lost)
  int        m_bad;      // outstanding bad symbols while locked
  int        m_good;     // good symbols since last bad / retirement
  bit        m_rd;
  int        m_errcnt;
  logic [9:0] m_sym;
  bit        m_k, m_err, m_ov;

  function automatic void model_reset();
    m_locked = 0; m_commas = 0; m_bad = 0; m_good = 0; m_rd = 0;
    m_errcnt = 0; m_sym = '0; m_k = 0; m_err = 0; m_ov = 0;
  endfunction

  function automatic void model_lose();
    m_locked = 0; m_commas = 0; m_bad = 0; m_good = 0; m_rd = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [9:0] s, input bit clr);
    int  n;
    bit  code, disp, bad, cpos, cneg, comma, kf;
    logic [5:0] pre;
    if (v) begin
      n     = $countones(s);
      code  = !(n == 4 || n == 5 || n == 6);
      disp  = !code && ((n == 6 && m_rd) || (n == 4 && !m_rd));
      bad   = code || disp;
      cpos  = (s[9:3] == 7'b0011111);
      cneg  = (s[9:3] == 7'b1100000);
      comma = (cpos || cneg) && !bad;
      pre   = s[9:4];
      kf    = (pre == 6'b001111) || (pre == 6'b110000);
      foreach (K_LIST[i]) if (s == K_LIST[i]) kf = 1;
      m_ov = m_locked; m_sym = s; m_k = kf; m_err = bad;
      if (m_locked) begin
        if (!code && n == 6) m_rd = 1;
        if (!code && n == 4) m_rd = 0;
        if (bad) begin
          if (m_errcnt < (1 << CW) - 1) m_errcnt++;
          m_bad++; m_good = 0;
          if (m_bad == BADL) model_lose();
        end else begin
          m_good++;
          if (m_good == GREC && m_bad > 0) begin m_bad--; m_good = 0; end
        end
      end else if (m_commas == 0) begin
        if (comma) begin
          m_rd = cpos;
          m_commas = 1;
          if (m_commas >= ACQ) m_locked = 1;
        end
      end else begin
        if (!code && n == 6) m_rd = 1;
        if (!code && n == 4) m_rd = 0;
        if (bad) model_lose();
        else if (comma) begin
          m_commas++;
          if (m_commas >= ACQ) m_locked = 1;
        end
      end
    end else begin
      m_ov = 0;
    end
    if (clr) m_errcnt = 0;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard: {sym,k,ov,err,sync,rd,cnt}
  // --------------------------------------------------------------------------
  logic [18:0] exp_q[$];

  function automatic logic [18:0] model_word();
    return {m_sym, m_k, m_ov, m_err, m_locked, m_rd, CW'(m_errcnt)};
  endfunction

  task automatic compare_word(input string tag);
    logic [18:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sym"},  int'(sym_out),   int'(e[18:9]));
    check({tag, "_k"},    int'(k_out),     int'(e[8]));
    check({tag, "_ov"},   int'(out_valid), int'(e[7]));
    check({tag, "_err"},  int'(sym_err),   int'(e[6]));
    check({tag, "_sync"}, int'(sync_ok),   int'(e[5]));
    check({tag, "_rd"},   int'(rd_pos),    int'(e[4]));
    check({tag, "_cnt"},  int'(err_cnt),   int'(e[3:0]));
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic step(input bit v, input logic [9:0] s, input bit clr, input string tag);
    @(negedge clk);
    sym_valid = v; sym_in = s; err_clr = clr;
    model_step(v, s, clr);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    compare_word(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sym_valid = 1'b0; sym_in = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(model_word());
    compare_word("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acquire();
    step(1, 10'b0011111010, 0, "acq1");
    step(1, 10'b1100000101, 0, "acq2");
    step(1, 10'b0011111010, 0, "acq3");
  endtask

  // --------------------------------------------------------------------------
  // Directed table
  // --------------------------------------------------------------------------
  typedef struct {
    logic       v;
    logic [9:0] s;
    logic       clr;
    logic       e_sync, e_ov, e_err, e_k, e_rd;
    logic [3:0] e_cnt;
    logic [9:0] e_sym;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [9:0] pool[8];
    logic [9:0] s;
    bit v, c;
    int  sel;

    rst_n = 1'b0; sym_valid = 1'b0; sym_in = '0; err_clr = 1'b0;

    //            v   sym            clr  sync ov  err  k   rd  cnt   sym_out
    tbl[0]  = '{1'b1, 10'b0011111010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 10'b0011111010};
    tbl[1]  = '{1'b1, 10'b1100000101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'b1100000101};
    tbl[2]  = '{1'b1, 10'b0011111010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 10'b0011111010};
    tbl[3]  = '{1'b1, 10'b1010101010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 10'b1010101010};
    tbl[4]  = '{1'b1, 10'b1010101010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 10'b1010101010};
    tbl[5]  = '{1'b1, 10'b1010101010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 10'b1010101010};
    tbl[6]  = '{1'b1, 10'b1010101010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 10'b1010101010};
    tbl[7]  = '{1'b0, 10'b0000000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 10'b1010101010};
    tbl[8]  = '{1'b1, 10'b1100000110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 10'b1100000110};
    tbl[9]  = '{1'b1, 10'b1101101000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 10'b1101101000};
    tbl[10] = '{1'b1, 10'b1100000110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 10'b1100000110};
    tbl[11] = '{1'b1, 10'b1110001110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 10'b1110001110};
    tbl[12] = '{1'b1, 10'b1110001110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 10'b1110001110};
    tbl[13] = '{1'b1, 10'b1111111111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 10'b1111111111};
    tbl[14] = '{1'b1, 10'b1111111111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 10'b1111111111};
    tbl[15] = '{1'b1, 10'b1010101010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 10'b1010101010};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym",  int'(sym_out),   0);
    check("rst_k",    int'(k_out),     0);
    check("rst_ov",   int'(out_valid), 0);
    check("rst_err",  int'(sym_err),   0);
    check("rst_sync", int'(sync_ok),   0);
    check("rst_rd",   int'(rd_pos),    0);
    check("rst_cnt",  int'(err_cnt),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: acquisition, pass-through, K flags, disparity errors, clear, loss
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sym_valid = tbl[i].v; sym_in = tbl[i].s; err_clr = tbl[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_sym", i),  int'(sym_out),   int'(tbl[i].e_sym));
      check($sformatf("tbl%0d_k", i),    int'(k_out),     int'(tbl[i].e_k));
      check($sformatf("tbl%0d_ov", i),   int'(out_valid), int'(tbl[i].e_ov));
      check($sformatf("tbl%0d_err", i),  int'(sym_err),   int'(tbl[i].e_err));
      check($sformatf("tbl%0d_sync", i), int'(sync_ok),   int'(tbl[i].e_sync));
      check($sformatf("tbl%0d_rd", i),   int'(rd_pos),    int'(tbl[i].e_rd));
      check($sformatf("tbl%0d_cnt", i),  int'(err_cnt),   int'(tbl[i].e_cnt));
    end

    // Loss: 4 code errors separated by 3 good symbols
    do_reset();
    acquire();
    for (int i = 0; i < 4; i++) begin
      step(1, 10'b1111111111, 0, "loss_err");
      if (i < 3) repeat (3) step(1, 10'b1010101010, 0, "loss_good");
    end
    check("loss_sync_after_4th", int'(sync_ok), 0);

    // Recovery: 4 good symbols between errors keep the lane up
    do_reset();
    acquire();
    for (int i = 0; i < 4; i++) begin
      step(1, 10'b1111111111, 0, "keep_err");
      repeat (4) step(1, 10'b1010101010, 0, "keep_good");
    end
    check("keep_sync", int'(sync_ok), 1);

    // Saturation of the 4-bit error counter
    for (int i = 0; i < 18; i++) begin
      step(1, 10'b1111111111, 0, "sat_err");
      repeat (4) step(1, 10'b1010101010, 0, "sat_good");
    end
    check("sat_cnt", int'(err_cnt), 15);

    // Clear coincident with an error
    step(1, 10'b1111111111, 1, "clr_err");
    check("clr_cnt", int'(err_cnt), 0);

    // Asynchronous reset in SYNC takes effect without a clock edge
    step(1, 10'b1010101010, 0, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_sym",  int'(sym_out),   0);
    check("arst_ov",   int'(out_valid), 0);
    check("arst_sync", int'(sync_ok),   0);
    check("arst_rd",   int'(rd_pos),    0);
    check("arst_cnt",  int'(err_cnt),   0);
    check("arst_err",  int'(sym_err),   0);
    model_reset();
    @(negedge clk);
    sym_valid = 1'b0;
    rst_n = 1'b1;
    // First symbol after reset is evaluated from LOSS
    acquire();
    step(1, 10'b1010101010, 0, "post_rst");

    // Randomised traffic against the model
    pool[0] = 10'b0011111010; pool[1] = 10'b1100000101;
    pool[2] = 10'b0011111000; pool[3] = 10'b1100000111;
    pool[4] = 10'b1010101010; pool[5] = 10'b1110001110;
    pool[6] = 10'b1100000110; pool[7] = 10'b1101101000;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 9) != 0);
      c   = ($urandom_range(0, 63) == 0);
      sel = $urandom_range(0, 11);
      if (sel < 8)       s = pool[sel];
      else if (sel == 8) s = 10'b1111111111;
      else if (sel == 9) s = 10'($urandom_range(0, 1023));
      else               s = pool[$urandom_range(0, 4)];
      step(v, s, c, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
